// File: rtl/inst_buffer_if.sv
// rtl/inst_buffer_if.sv - packet type and fetch/dispatch bus for the instruction buffer
package inst_buffer_pkg;

  // One fetched instruction with its PC and predicted next PC.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } IF_IB_PACKET;

endpackage

interface inst_buffer_if #(
  parameter int DEPTH = 8
);
  import inst_buffer_pkg::*;

  IF_IB_PACKET               if_ib_packet;
  logic                      squash;
  logic                      dp_pop;
  IF_IB_PACKET               ib_dp_packet;
  logic                      ib_full;
  logic                      ib_empty;
  logic [$clog2(DEPTH):0]    ib_count;
  logic                      ib_overflow;

  // Fetch/dispatch side drives packets and control, observes buffer status.
  modport master (
    output if_ib_packet, squash, dp_pop,
    input  ib_dp_packet, ib_full, ib_empty, ib_count, ib_overflow
  );

  // The buffer itself.
  modport slave (
    input  if_ib_packet, squash, dp_pop,
    output ib_dp_packet, ib_full, ib_empty, ib_count, ib_overflow
  );

endinterface

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - circular instruction FIFO between fetch and dispatch; optional IB_BYPASS_EN
`ifndef MEM_LATENCY_IN_CYCLES
`define MEM_LATENCY_IN_CYCLES 2
`endif

module inst_buffer #(
  parameter int DEPTH = 8,
  parameter int SKID  = `MEM_LATENCY_IN_CYCLES
) (
  input logic           clock,
  input logic           reset,
  inst_buffer_if.slave  ib
);
  import inst_buffer_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] SKID_C  = CW'(SKID);

  IF_IB_PACKET   entry [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow;

  logic empty;
  logic at_depth;
  logic push;
  logic pop;
  logic bypass;
  logic wr;
  logic drop;

  // Decode this cycle's push/pop; squash suppresses both, and a full buffer
  // still accepts a push when the head is being vacated in the same cycle.
  always_comb begin
    empty    = (count == '0);
    at_depth = (count == DEPTH_C);
    push     = ib.if_ib_packet.valid && !ib.squash;
    pop      = ib.dp_pop && !empty && !ib.squash;
`ifdef IB_BYPASS_EN
    bypass   = empty && push && ib.dp_pop;
`else
    bypass   = 1'b0;
`endif
    wr       = push && !bypass && (!at_depth || pop);
    drop     = push && !bypass && at_depth && !pop;
  end

  // Pointer, occupancy, storage and sticky overflow update.
  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else if (ib.squash) begin
      // Entry contents are left stale; the output is masked while empty.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        entry[tail] <= ib.if_ib_packet;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (wr && !pop) begin
        count <= count + 1'b1;
      end else if (!wr && pop) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Head presentation; zeroed when empty so dispatch sees valid=0.
  always_comb begin
    ib.ib_dp_packet = empty ? '0 : entry[head];
`ifdef IB_BYPASS_EN
    if (bypass) begin
      ib.ib_dp_packet = ib.if_ib_packet;
    end
`endif
  end

  // Status is register-only so fetch can use ib_full in the same cycle.
  // ib_full reserves SKID slots for packets already in the memory pipeline.
  assign ib.ib_empty    = empty;
  assign ib.ib_count    = count;
  assign ib.ib_full     = ((DEPTH_C - count) <= SKID_C);
  assign ib.ib_overflow = overflow;

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - scoreboard testbench for inst_buffer
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  inst_buffer_if #(.DEPTH(8)) bus ();

  inst_buffer #(.DEPTH(8), .SKID(2)) dut (
    .clock (clock),
    .reset (reset),
    .ib    (bus)
  );

  int          checks    = 0;
  int          failures  = 0;
  int          max_count = 0;
  IF_IB_PACKET exp_q[$];

  function automatic IF_IB_PACKET mk(input logic [31:0] pc);
    IF_IB_PACKET p;
    p.inst  = pc ^ 32'hA5A5_0000;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    p.valid = 1'b1;
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.if_ib_packet = '0;
    bus.dp_pop       = 1'b0;
    bus.squash       = 1'b0;
  endtask

  // One clock of stimulus; acc marks a packet the buffer must eventually emit.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic pop,
                     input logic sq, input logic acc);
    IF_IB_PACKET p;
    p = v ? mk(pc) : '0;
    bus.if_ib_packet = p;
    bus.dp_pop       = pop;
    bus.squash       = sq;
    if (sq) exp_q.delete();
    if (acc) exp_q.push_back(p);
    @(posedge clock);
    #1;
    idle();
    if (int'(bus.ib_count) > max_count) max_count = int'(bus.ib_count);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!bus.ib_empty && n < 20) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk({name, "_empty"}, 128'(bus.ib_empty), 128'(1));
    chk({name, "_scoreboard_left"}, 128'(exp_q.size()), 128'(0));
  endtask

  // Monitor: every packet dispatch actually takes must be the oldest expected one.
  always @(negedge clock) begin : monitor
    IF_IB_PACKET e;
    if (reset === 1'b0 && bus.dp_pop && !bus.squash && bus.ib_dp_packet.valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dispatch_unexpected actual_pc=%0h required=none", bus.ib_dp_packet.PC);
      end else begin
        e = exp_q.pop_front();
        chk("dispatch_packet", 128'(bus.ib_dp_packet), 128'(e));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_count",    128'(bus.ib_count),     128'(0));
    chk("reset_empty",    128'(bus.ib_empty),     128'(1));
    chk("reset_full",     128'(bus.ib_full),      128'(0));
    chk("reset_overflow", 128'(bus.ib_overflow),  128'(0));
    chk("reset_packet",   128'(bus.ib_dp_packet), 128'(0));
    reset = 1'b0;

    // Three pushes, no pop.
    cyc(1'b1, 32'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h04, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h08, 1'b0, 1'b0, 1'b1);
    chk("fill3_count", 128'(bus.ib_count), 128'(3));
    chk("fill3_empty", 128'(bus.ib_empty), 128'(0));
    chk("fill3_head",  128'(bus.ib_dp_packet.PC), 128'(32'h0));
    chk("fill3_full",  128'(bus.ib_full), 128'(0));

    // Fill towards DEPTH; ib_full rises at count 6 with SKID=2.
    cyc(1'b1, 32'h0C, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 1'b1);
    chk("cnt5_full", 128'(bus.ib_full), 128'(0));
    cyc(1'b1, 32'h14, 1'b0, 1'b0, 1'b1);
    chk("cnt6_count", 128'(bus.ib_count), 128'(6));
    chk("cnt6_full",  128'(bus.ib_full),  128'(1));
    cyc(1'b1, 32'h18, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h1C, 1'b0, 1'b0, 1'b1);
    chk("cnt8_count",    128'(bus.ib_count),    128'(8));
    chk("cnt8_overflow", 128'(bus.ib_overflow), 128'(0));
    cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    chk("drop_count",    128'(bus.ib_count),    128'(8));
    chk("drop_overflow", 128'(bus.ib_overflow), 128'(1));
    chk("drop_head",     128'(bus.ib_dp_packet.PC), 128'(32'h0));

    // Push and pop together while full.
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
    chk("fullpp_count", 128'(bus.ib_count), 128'(8));
    chk("fullpp_head",  128'(bus.ib_dp_packet.PC), 128'(32'h4));
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("pop7_full", 128'(bus.ib_full), 128'(1));
    drain("fullpp");
    chk("drain_full",     128'(bus.ib_full),     128'(0));
    chk("drain_overflow", 128'(bus.ib_overflow), 128'(1));

    // Reset mid-stream beats a valid push.
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
    bus.if_ib_packet = mk(32'h84);
    bus.dp_pop       = 1'b1;
    reset            = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle();
    chk("midreset_count",    128'(bus.ib_count),    128'(0));
    chk("midreset_overflow", 128'(bus.ib_overflow), 128'(0));
    chk("midreset_packet",   128'(bus.ib_dp_packet), 128'(0));

    // Streaming through more than 2*DEPTH packets; pointers wrap.
    max_count = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 32'(i * 4), (i >= 3), 1'b0, 1'b1);
    end
    chk("wrap_count", 128'(bus.ib_count), 128'(3));
    drain("wrap");
    chk("wrap_max_le8", 128'(max_count <= 8), 128'(1));

    // Squash beats push and pop.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
    end
    chk("presquash_count", 128'(bus.ib_count), 128'(5));
    cyc(1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
    chk("squash_count", 128'(bus.ib_count), 128'(0));
    chk("squash_empty", 128'(bus.ib_empty), 128'(1));
    chk("squash_valid", 128'(bus.ib_dp_packet.valid), 128'(0));
    cyc(1'b1, 32'h400, 1'b0, 1'b0, 1'b1);
    chk("postsquash_head", 128'(bus.ib_dp_packet.PC), 128'(32'h400));
    drain("squash");

    // Fetch-to-dispatch latency from an empty buffer.
`ifdef IB_BYPASS_EN
    bus.if_ib_packet = mk(32'h100);
    bus.dp_pop       = 1'b1;
    exp_q.push_back(mk(32'h100));
    #1;
    chk("bypass_pc",    128'(bus.ib_dp_packet.PC),    128'(32'h100));
    chk("bypass_valid", 128'(bus.ib_dp_packet.valid), 128'(1));
    @(posedge clock);
    #1;
    idle();
    chk("bypass_count", 128'(bus.ib_count), 128'(0));
    chk("bypass_scoreboard_left", 128'(exp_q.size()), 128'(0));
`else
    cyc(1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
    chk("latency_count", 128'(bus.ib_count), 128'(1));
    chk("latency_head",  128'(bus.ib_dp_packet.PC), 128'(32'h100));
    drain("latency");
`endif

    repeat (2) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Instruction buffer between fetch and dispatch. It accepts one IF_IB_PACKET per cycle from if_stage and presents the oldest entry to dispatch.
- Circular FIFO with occupancy-based ib_full back-pressure to fetch.
- ib_full asserts early enough to absorb packets still in flight in the instruction-memory latency pipeline.
- Squash empties the buffer on a taken branch or mispredict.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- SKID, `MEM_LATENCY_IN_CYCLES, number of entries kept free for in-flight fetches; must be < DEPTH.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- if_ib_packet  input  $bits(IF_IB_PACKET)  fetched packet (inst, PC, NPC, valid); pushed when .valid=1.
- squash  input  1  flush all entries; the same-cycle input packet is discarded.
- dp_pop  input  1  dispatch consumes the head entry this cycle.
- ib_dp_packet  output  $bits(IF_IB_PACKET)  head entry; '0 when empty.
- ib_full  output  1  back-pressure to if_stage.
- ib_empty  output  1  no valid entries.
- ib_count  output  $clog2(DEPTH)+1  occupancy.
- ib_overflow  output  1  sticky error: a push was dropped.

Behaviour:
- Storage: DEPTH entries, head pointer, tail pointer, count register; pointers wrap modulo DEPTH.
- Reset (synchronous, active-high):
  - head=tail=count=0, ib_overflow=0, entry array cleared.
  - Outputs after reset: ib_dp_packet='0, ib_empty=1, ib_full=0, ib_count=0.
  - Reset has priority over all other inputs, including mid-stream.
- push = if_ib_packet.valid && !squash.
- pop = dp_pop && !ib_empty && !squash. A pop while empty is ignored; it is not an error.
- Every output depends only on registered state; no input-to-output combinational path. This holds because if_stage uses ib_full combinationally in the same cycle.
- ib_empty = (count==0).
- ib_count = count.
- ib_dp_packet = entry[head] when !ib_empty, else '0, so valid=0 when empty.
- ib_full = ((DEPTH - count) <= SKID).
  - With SKID=L, up to L packets that issued before ib_full rose still fit.
  - A pop lowers ib_full only on the next cycle.
- Push only: entry[tail]<=if_ib_packet, tail<=tail+1, count<=count+1.
- Pop only: head<=head+1, count<=count-1.
- Push and pop in the same cycle:
  - Both take effect; count unchanged.
  - Legal even when count==DEPTH: the head slot is vacated as the tail is written.
  - When count==1, the new entry becomes the head on the next cycle.
- Push with count==DEPTH and no pop:
  - Packet dropped; state unchanged.
  - ib_overflow<=1 and holds until reset.
- Squash:
  - Next cycle: head=tail=0, count=0.
  - Entry contents are don't-care, since the output is masked by empty.
  - ib_overflow unaffected.
  - Squash beats push and pop in the same cycle.
- Ordering: strict FIFO. PC order at the output equals PC order of accepted pushes.
- Latency: a packet pushed in cycle N appears on ib_dp_packet in cycle N+1 if the buffer was empty.

Optional Feature:
- Macro: IB_BYPASS_EN.
- Defined:
  - When ib_empty && push && dp_pop && !squash, ib_dp_packet=if_ib_packet combinationally.
  - The packet is consumed the same cycle and never written; pointers and count are unchanged.
  - Zero-cycle fetch-to-dispatch latency when the buffer is empty.
  - ib_dp_packet gains a combinational input path; ib_full, ib_empty and ib_count stay register-only.
- Undefined:
  - Behaviour exactly as specified above; minimum latency 1 cycle.

Test Plan:
- Reset, then push PCs 0x0, 0x4, 0x8 on consecutive cycles with no pop -> ib_count=3; head PC=0x0; ib_empty=0.
- DEPTH=8, SKID=2: push 6 packets with no pop -> ib_full=1 once count=6; two more pushes accepted (count=8); a ninth push dropped, ib_overflow=1, head PC still the first.
- Full (count=8) with simultaneous push PC=0x40 and dp_pop -> count stays 8; head advances; 0x40 emerges after the 7 older entries.
- Push and pop across more than 2*DEPTH packets (PCs 0x0..0x7C) -> pointers wrap; output PCs strictly ascending by 4; no loss; count never exceeds 8.
- Count=5, assert squash with a valid push and dp_pop in the same cycle -> next cycle count=0, ib_empty=1, ib_dp_packet.valid=0; the pushed packet is absent.
- IB_BYPASS_EN, empty buffer, push PC=0x100 with dp_pop -> same cycle ib_dp_packet.PC=0x100, valid=1; next cycle count=0. Without the macro: PC=0x100 appears one cycle later with count=1.
